// File: rtl/fp_result_packer.sv
// fp_result_packer
// Takes multiplier results in the internal format (SP-biased exponent,
// 23-bit mantissa, upstream flags), packs them into an IEEE single or half
// word, and buffers them in a small FIFO towards the consumer.
//
// Datapath: accept -> pack stage register -> FIFO (FIFO_DEPTH entries).
// in_ready counts the pack stage as occupied space, so an accepted result
// always finds a FIFO slot on the following edge and nothing is dropped.
//
// Build option: define FP_PACK_STICKY_FLAGS_EN to build the sticky flag
// accumulator (sticky_flags / flags_clr). Without it sticky_flags is tied
// to zero and flags_clr is ignored.

module fp_result_packer #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        mode_fp,
    input  logic        round_mode,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [22:0] in_mant,
    input  logic        in_overflow,
    input  logic        in_underflow,
    input  logic        in_inexact,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_flags,
    input  logic        flags_clr,
    output logic [2:0]  sticky_flags
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // half-precision bias difference: 127 - 15
    localparam logic [8:0] HP_BIAS_ADJ = 9'd112;

    logic        accept;
    logic        pop;

    // single-precision packing results
    logic [31:0] sp_data;
    logic [2:0]  sp_flags;

    // half-precision intermediate values
    logic [8:0]  hp_e_raw;
    logic [9:0]  hp_m;
    logic        hp_guard;
    logic        hp_sticky;
    logic        hp_round_up;
    logic [10:0] hp_m_inc;
    logic [8:0]  hp_e_fin;
    logic [9:0]  hp_m_fin;
    logic        hp_inexact;
    logic [31:0] hp_data;
    logic [2:0]  hp_flags;

    logic [31:0] pack_data_next;
    logic [2:0]  pack_flags_next;

    // pack stage
    logic        pack_valid;
    logic [31:0] pack_data;
    logic [2:0]  pack_flags;

    // output FIFO, entries hold {flags, data}
    logic [34:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic [34:0]   head_entry;

    // Single precision: specials collapse to signed infinity or signed zero
    always_comb begin
        sp_data  = '0;
        sp_flags = {in_overflow, in_underflow, in_inexact};
        if (in_overflow || (in_exp == 8'hFF)) begin
            sp_data = {in_sign, 8'hFF, 23'h0};
        end else if (in_underflow || (in_exp == 8'h00)) begin
            sp_data = {in_sign, 31'h0};
        end else begin
            sp_data = {in_sign, in_exp, in_mant};
        end
    end

    // Half precision: rebias, round to 10 mantissa bits, handle carry-out
    always_comb begin
        hp_e_raw    = {1'b0, in_exp} - HP_BIAS_ADJ;
        hp_m        = in_mant[22:13];
        hp_guard    = in_mant[12];
        hp_sticky   = |in_mant[11:0];
        hp_round_up = ~round_mode & hp_guard & (hp_sticky | hp_m[0]);
        hp_m_inc    = {1'b0, hp_m} + 11'd1;
        hp_e_fin    = hp_e_raw;
        hp_m_fin    = hp_m;
        if (hp_round_up) begin
            if (hp_m_inc[10]) begin
                // mantissa wrapped to zero, bump the exponent instead
                hp_m_fin = '0;
                hp_e_fin = hp_e_raw + 9'd1;
            end else begin
                hp_m_fin = hp_m_inc[9:0];
            end
        end
        hp_inexact = in_inexact | (|in_mant[12:0]);
    end

    // Half precision: select special/normal encoding and flags
    always_comb begin
        hp_data  = '0;
        hp_flags = '0;
        if (in_overflow) begin
            hp_data  = {16'h0, in_sign, 5'h1F, 10'h0};
            hp_flags = 3'b101;
        end else if (in_underflow || (in_exp <= 8'd112)) begin
            // too small for a half normal: flush to signed zero
            hp_data  = {16'h0, in_sign, 15'h0};
            hp_flags = {1'b0, 1'b1, in_inexact | (|in_mant)};
        end else if (hp_e_fin >= 9'd31) begin
            hp_data  = {16'h0, in_sign, 5'h1F, 10'h0};
            hp_flags = 3'b101;
        end else begin
            hp_data  = {16'h0, in_sign, hp_e_fin[4:0], hp_m_fin};
            hp_flags = {1'b0, 1'b0, hp_inexact};
        end
    end

    // Format select for the word entering the pack stage
    always_comb begin
        pack_data_next  = hp_data;
        pack_flags_next = hp_flags;
        if (mode_fp) begin
            pack_data_next  = sp_data;
            pack_flags_next = sp_flags;
        end
    end

    // Handshakes and free-space accounting (pack stage counts as occupied)
    always_comb begin
        occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, pack_valid};
        in_ready   = occupancy < (CW + 1)'(FIFO_DEPTH);
        accept     = in_valid & in_ready;
        out_valid  = fifo_count != '0;
        pop        = out_valid & out_ready;
        head_entry = fifo_mem[rd_ptr];
        out_data   = out_valid ? head_entry[31:0] : 32'h0;
        out_flags  = out_valid ? head_entry[34:32] : 3'b000;
    end

    // Pack stage register
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_valid <= 1'b0;
            pack_data  <= '0;
            pack_flags <= '0;
        end else begin
            pack_valid <= accept;
            if (accept) begin
                pack_data  <= pack_data_next;
                pack_flags <= pack_flags_next;
            end
        end
    end

    // FIFO storage; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (pack_valid) begin
            fifo_mem[wr_ptr] <= {pack_flags, pack_data};
        end
    end

    // FIFO pointers and count; power-of-two depth gives natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (pack_valid) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (pack_valid && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!pack_valid && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

`ifdef FP_PACK_STICKY_FLAGS_EN
    logic [2:0] sticky_q;

    // Sticky accumulator; a pop in the clear cycle still lands its flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= '0;
        end else if (pop) begin
            sticky_q <= (flags_clr ? 3'b000 : sticky_q) | head_entry[34:32];
        end else if (flags_clr) begin
            sticky_q <= '0;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_flags_clr;

    assign unused_flags_clr = flags_clr;
    assign sticky_flags     = 3'b000;
`endif

endmodule

// File: tb/tb_fp_result_packer.sv
// Testbench for fp_result_packer: directed cases with known IEEE words,
// backpressure, random traffic against a reference model, and reset
// in the middle of buffered traffic.

module tb_fp_result_packer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        mode_fp;
    logic        round_mode;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    logic        in_overflow;
    logic        in_underflow;
    logic        in_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;
    logic        flags_clr;
    logic [2:0]  sticky_flags;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [2:0]  exp_sticky = 3'b000;
    logic [34:0] exp_q[$];

    fp_result_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode_fp(mode_fp), .round_mode(round_mode),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_overflow(in_overflow), .in_underflow(in_underflow), .in_inexact(in_inexact),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags),
        .flags_clr(flags_clr), .sticky_flags(sticky_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] sticky_expected();
`ifdef FP_PACK_STICKY_FLAGS_EN
        return exp_sticky;
`else
        return 3'b000;
`endif
    endfunction

    // Reference: returns {ovf, unf, inx, word} computed with integer arithmetic
    function automatic logic [34:0] model(input bit mode, input bit rm, input bit sign,
                                          input logic [7:0] ex, input logic [22:0] mant,
                                          input bit ovf, input bit unf, input bit inx);
        int          e;
        int          m;
        int          rem;
        bit          x;
        logic [31:0] inf_h;
        inf_h = (32'(sign) << 15) | 32'h7C00;
        if (mode) begin
            if (ovf || ex == 8'd255) return {ovf, unf, inx, sign, 8'hFF, 23'h0};
            if (unf || ex == 8'd0)   return {ovf, unf, inx, sign, 31'h0};
            return {ovf, unf, inx, sign, ex, mant};
        end
        if (ovf) return {3'b101, inf_h};
        if (unf || int'(ex) <= 112) return {1'b0, 1'b1, (inx || mant != 0), 32'(sign) << 15};
        e   = int'(ex) - 112;
        m   = int'(mant) / 8192;
        rem = int'(mant) % 8192;
        x   = inx || (rem != 0);
        if (!rm && (rem > 4096 || (rem == 4096 && (m % 2) == 1))) m = m + 1;
        if (m == 1024) begin
            m = 0;
            e = e + 1;
        end
        if (e >= 31) return {3'b101, inf_h};
        return {2'b00, x, (32'(sign) << 15) | (32'(e) << 10) | 32'(m)};
    endfunction

    // Called after inputs are driven at a falling edge: scores the handshakes
    // that the coming rising edge will perform.
    task automatic observe();
        logic [34:0] e;
        chk("in_ready_space", 35'(in_ready), 35'(exp_q.size() < DEPTH));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 35'(out_valid), 35'(0));
            end else begin
                e = exp_q.pop_front();
                chk("out_data", 35'(out_data), 35'(e[31:0]));
                chk("out_flags", 35'(out_flags), 35'(e[34:32]));
                exp_sticky = (flags_clr ? 3'b000 : exp_sticky) | e[34:32];
            end
        end else if (flags_clr) begin
            exp_sticky = 3'b000;
        end
        if (in_valid && in_ready)
            exp_q.push_back(model(mode_fp, round_mode, in_sign, in_exp, in_mant,
                                  in_overflow, in_underflow, in_inexact));
    endtask

    task automatic drive(input bit mode, input bit rm, input bit sign, input logic [7:0] ex,
                         input logic [22:0] mant, input bit ovf, input bit unf, input bit inx);
        mode_fp = mode; round_mode = rm; in_sign = sign; in_exp = ex; in_mant = mant;
        in_overflow = ovf; in_underflow = unf; in_inexact = inx;
    endtask

    task automatic directed(input string tag, input bit mode, input bit rm, input bit sign,
                            input logic [7:0] ex, input logic [22:0] mant,
                            input logic [31:0] want_data, input logic [2:0] want_flags);
        @(negedge clk);
        drive(mode, rm, sign, ex, mant, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1; flags_clr = 1'b0;
        chk({tag, "_in_ready"}, 35'(in_ready), 35'(1));
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, 35'(out_valid), 35'(0));
        @(negedge clk);
        chk({tag, "_lat2"}, 35'(out_valid), 35'(1));
        chk({tag, "_data"}, 35'(out_data), 35'(want_data));
        chk({tag, "_flags"}, 35'(out_flags), 35'(want_flags));
        exp_sticky = exp_sticky | want_flags;
        @(negedge clk);
        chk({tag, "_popped"}, 35'(out_valid), 35'(0));
        chk({tag, "_sticky"}, 35'(sticky_flags), 35'(sticky_expected()));
    endtask

    task automatic pulse_clr(input string tag);
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        exp_sticky = 3'b000;
        chk(tag, 35'(sticky_flags), 35'(0));
    endtask

    task automatic drain(input string tag, input int budget);
        int b;
        b = budget;
        in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
        while (exp_q.size() > 0 && b > 0) begin
            observe();
            @(negedge clk);
            b--;
        end
        chk({tag, "_drained"}, 35'(exp_q.size()), 35'(0));
        repeat (2) @(negedge clk);
        chk({tag, "_no_dup"}, 35'(out_valid), 35'(0));
        chk({tag, "_sticky"}, 35'(sticky_flags), 35'(sticky_expected()));
    endtask

    initial begin
        int acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flags_clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h0, 23'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 35'(out_valid), 35'(0));
        chk("rst_out_data", 35'(out_data), 35'(0));
        chk("rst_out_flags", 35'(out_flags), 35'(0));
        chk("rst_sticky", 35'(sticky_flags), 35'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 35'(in_ready), 35'(1));

        directed("sp_basic", 1'b1, 1'b0, 1'b0, 8'h80, 23'h400000, 32'h40400000, 3'b000);
        directed("hp_rne_carry", 1'b0, 1'b0, 1'b0, 8'h7F, 23'h7FF000, 32'h00004000, 3'b001);
        directed("hp_trunc", 1'b0, 1'b1, 1'b0, 8'h7F, 23'h7FF000, 32'h00003FFF, 3'b001);
        directed("hp_rnd_ovf", 1'b0, 1'b0, 1'b1, 8'h8E, 23'h7FF000, 32'h0000FC00, 3'b101);
        pulse_clr("clr_before_unf");
        directed("hp_unf", 1'b0, 1'b0, 1'b0, 8'h70, 23'h000001, 32'h00000000, 3'b011);
`ifdef FP_PACK_STICKY_FLAGS_EN
        chk("unf_sticky_value", 35'(sticky_flags), 35'(3'b011));
`else
        chk("unf_sticky_value", 35'(sticky_flags), 35'(3'b000));
`endif
        pulse_clr("clr_after_unf");

        // Backpressure: four back-to-back offers with the consumer stalled
        @(negedge clk);
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h80 + i), 23'(i * 3 + 1), 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1;
            if (i >= 2) chk("bp_in_ready_low", 35'(in_ready), 35'(0));
            if (in_ready) acc++;
            observe();
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_accepted", 35'(acc), 35'(DEPTH));
        chk("bp_full_valid", 35'(out_valid), 35'(1));
        drain("bp", 20);

        // Random traffic with occasional flag clears
        for (int c = 0; c < 600; c++) begin
            logic [7:0] ex;
            case ($urandom_range(0, 7))
                0: ex = 8'($urandom);
                1: ex = 8'h00;
                2: ex = 8'hFF;
                3: ex = 8'(112 + $urandom_range(0, 1));
                4: ex = 8'(141 + $urandom_range(0, 2));
                default: ex = 8'($urandom_range(100, 150));
            endcase
            drive(1'($urandom), 1'($urandom), 1'($urandom), ex,
                  ($urandom_range(0, 3) == 0) ? 23'(23'h7FF000 | ($urandom & 32'h1FFF)) : 23'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flags_clr = ($urandom_range(0, 19) == 0);
            observe();
            @(negedge clk);
            chk("rand_sticky", 35'(sticky_flags), 35'(sticky_expected()));
        end
        drain("rand", 40);

        // Reset with words buffered and sticky flags set
        directed("pre_rst_unf", 1'b0, 1'b0, 1'b1, 8'h10, 23'h000100, 32'h00008000, 3'b011);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'(8'h90 + i), 23'h123, 1'b0, 1'b0, 1'b1);
            in_valid = 1'b1;
            observe();
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_buffered", 35'(out_valid), 35'(1));
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", 35'(out_valid), 35'(0));
        chk("mid_rst_out_data", 35'(out_data), 35'(0));
        chk("mid_rst_sticky", 35'(sticky_flags), 35'(0));
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        exp_sticky = 3'b000;
        @(negedge clk);
        chk("mid_rst_in_ready", 35'(in_ready), 35'(1));
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_stale", 35'(out_valid), 35'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
